count_seq_checker: RTL

//  Receive-side checker for the free-running count stream the counter block drives.

---
 rtl/count_seq_checker.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/count_seq_checker.sv
// -----------------------------------------------------------------------------
// count_seq_checker
//
// Receive-side checker for a free-running incrementing count stream. It seeds
// on the first valid sample and searches for LOCK_CNT consecutive in-sequence
// samples before declaring lock. While locked, each out-of-sequence sample is
// flagged with a one-cycle strobe and counted in a saturating error counter.
// The expected value free-wheels across isolated errors. LOSS_CNT consecutive
// errors drop the checker back to searching, reseeded from the offending sample.
// All arithmetic on the count stream is modulo 2^WIDTH, so a wrap is in-sequence.
//
// Optional feature (macro SEQ_CHK_STICKY_EN):
//   Adds the err_sticky output. It is set on any edge that raises err_pulse and
//   is held until err_clr or reset. The set wins over a same-edge err_clr.
//   With the macro undefined, the port and its register do not exist.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   in_valid   in   1      in_data carries a sample this cycle
//   in_data    in   WIDTH  observed count value
//   err_clr    in   1      synchronous clear of err_count (and err_sticky)
//   locked     out  1      high while the checker is in LOCKED
//   err_pulse  out  1      one-cycle strobe per mismatch counted in LOCKED
//   err_count  out  ERR_W  saturating count of LOCKED mismatches
//   expected   out  WIDTH  next value the checker expects
//   err_sticky out  1      sticky error flag (SEQ_CHK_STICKY_EN only)
// -----------------------------------------------------------------------------
module count_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
`ifdef SEQ_CHK_STICKY_EN
    ,
    output logic             err_sticky
`endif
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    localparam logic [WIDTH-1:0]   STEP_V = WIDTH'(STEP);
    localparam logic [MATCH_W-1:0] LOCK_V = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_V = MISS_W'(LOSS_CNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state_r;
    logic               locked_r;
    logic               err_pulse_r;
    logic [ERR_W-1:0]   err_count_r;
    logic [WIDTH-1:0]   expected_r;
    logic [MATCH_W-1:0] match_cnt_r;
    logic [MISS_W-1:0]  miss_cnt_r;

    logic               match_s;
    logic               err_hit_s;
    logic               err_sat_s;
    logic [MATCH_W-1:0] match_inc_s;
    logic [MISS_W-1:0]  miss_inc_s;

    // Next value in the count sequence; wraps naturally at 2^WIDTH.
    function automatic logic [WIDTH-1:0] seq_next(input logic [WIDTH-1:0] value);
        return value + STEP_V;
    endfunction

    // Sample classification and incremented counters shared by the FSM and error logic.
    always_comb begin
        match_s     = 1'b0;
        err_hit_s   = 1'b0;
        err_sat_s   = 1'b0;
        match_inc_s = MATCH_W'(0);
        miss_inc_s  = MISS_W'(0);

        match_s     = (in_data == expected_r);
        match_inc_s = match_cnt_r + MATCH_W'(1);
        miss_inc_s  = miss_cnt_r + MISS_W'(1);
        err_sat_s   = &err_count_r;
        if (in_valid && (state_r == ST_LOCKED) && !match_s) begin
            err_hit_s = 1'b1;
        end else begin
            err_hit_s = 1'b0;
        end
    end

    // Lock FSM: seeding, searching, locked tracking, and the error strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            expected_r  <= WIDTH'(0);
            match_cnt_r <= MATCH_W'(0);
            miss_cnt_r  <= MISS_W'(0);
        end else begin
            err_pulse_r <= 1'b0;
            if (in_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        expected_r  <= seq_next(in_data);
                        match_cnt_r <= MATCH_W'(1);
                        state_r     <= ST_SEARCH;
                        locked_r    <= 1'b0;
                    end
                    ST_SEARCH: begin
                        if (match_s) begin
                            expected_r  <= seq_next(expected_r);
                            match_cnt_r <= match_inc_s;
                            if (match_inc_s == LOCK_V) begin
                                state_r    <= ST_LOCKED;
                                locked_r   <= 1'b1;
                                miss_cnt_r <= MISS_W'(0);
                            end else begin
                                state_r    <= ST_SEARCH;
                            end
                        end else begin
                            // Reseed from the out-of-sequence sample and start over.
                            expected_r  <= seq_next(in_data);
                            match_cnt_r <= MATCH_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (match_s) begin
                            expected_r <= seq_next(expected_r);
                            miss_cnt_r <= MISS_W'(0);
                        end else begin
                            err_pulse_r <= 1'b1;
                            if (miss_inc_s == LOSS_V) begin
                                state_r     <= ST_SEARCH;
                                locked_r    <= 1'b0;
                                expected_r  <= seq_next(in_data);
                                match_cnt_r <= MATCH_W'(1);
                                miss_cnt_r  <= MISS_W'(0);
                            end else begin
                                // Free-wheel across an isolated error.
                                expected_r <= seq_next(expected_r);
                                miss_cnt_r <= miss_inc_s;
                            end
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        locked_r    <= 1'b0;
                        match_cnt_r <= MATCH_W'(0);
                        miss_cnt_r  <= MISS_W'(0);
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Saturating error counter; a same-edge clear wins over an increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_r <= ERR_W'(0);
        end else if (err_clr) begin
            err_count_r <= ERR_W'(0);
        end else if (err_hit_s && !err_sat_s) begin
            err_count_r <= err_count_r + ERR_W'(1);
        end else begin
            err_count_r <= err_count_r;
        end
    end

`ifdef SEQ_CHK_STICKY_EN
    logic err_sticky_r;

    // Sticky error flag; a new error takes priority over a same-edge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sticky_r <= 1'b0;
        end else if (err_hit_s) begin
            err_sticky_r <= 1'b1;
        end else if (err_clr) begin
            err_sticky_r <= 1'b0;
        end else begin
            err_sticky_r <= err_sticky_r;
        end
    end

    assign err_sticky = err_sticky_r;
`endif

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;
    assign err_count = err_count_r;
    assign expected  = expected_r;

endmodule
